seq_waveform_gen: RTL and testbench
===================================

Name: seq_waveform_gen

Overview:
Serial waveform transmitter. It accepts a parallel bit pattern, a length and a repeat flag over a valid/ready load interface, then plays the pattern out one bit per cycle on f, LSB first. It is the driving end of the single-bit sequential waveform interface (a in, f out) that the sequential boolean and waveform problem blocks consume. It is used to generate stimulus waveforms in the same clock domain.

Parameters:
nbits, 16, maximum pattern length in bits (>= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load_val  input  1  load request valid
load_rdy  output  1  block can accept a load this cycle
load_pattern  input  nbits  bits to play; bit 0 goes out first
load_len  input  $clog2(nbits)  pattern length minus 1 (0 means 1 bit, nbits-1 means nbits bits)
load_repeat  input  1  1 = loop pattern until stop; 0 = play once
stop  input  1  abort playback
f  output  1  current waveform bit
f_val  output  1  f carries a pattern bit this cycle
done  output  1  last bit of a non-repeat playback is on f this cycle

Behaviour:
- Registered state: fsm (IDLE, PLAY), pat[nbits], len, rep, idx[$clog2(nbits)].
- Reset (reset==0, asynchronous): fsm=IDLE and all registers 0. Outputs settle immediately to f=0, f_val=0, done=0, load_rdy=1. This also applies mid-playback, with no wait for a clock edge.
- Outputs are combinational from registered state, plus stop for load_rdy:
  - f = (fsm==PLAY) ? pat[idx] : 0
  - f_val = (fsm==PLAY)
  - last = PLAY && idx==len
  - done = last && !rep
  - load_rdy = IDLE || (done && !stop)
- Handshake: a load is accepted on the rising edge where load_val && load_rdy. On accept, the block latches pat/len/rep and sets idx=0, fsm=PLAY. The first pattern bit appears on f in the cycle after the accepting edge, so latency is 1 cycle.
- load_val while load_rdy=0: ignored, not queued. The source must hold its request.
- PLAY, per edge, highest priority first:
  1. stop=1 -> IDLE. The bit on f in the stop cycle counts as emitted. Any load in that cycle is refused because load_rdy=0.
  2. idx<len -> idx+1.
  3. last && rep -> idx=0, stay PLAY, giving a seamless wrap with no gap cycle.
  4. last && !rep && load accepted -> new pattern, idx=0, stay PLAY. Playback is gapless back-to-back.
  5. last && !rep && no load -> IDLE.
- IDLE: stop is ignored. A load accept goes to PLAY.
- Once a playback is accepted, load_pattern, load_len and load_repeat are don't-care; later input changes do not affect it.
- Bits of pat above len are never output.
- idx never exceeds len. No wrap arithmetic on idx other than the reset-to-0 in steps 3 and 4.

Test Plan:
Unless noted, nbits=8. Cycle 1 is the first cycle after the accepting edge.
1. Reset and idle: reset=0 for 2 cycles, then 1, with load_val=0 and stop toggling -> f=0, f_val=0, done=0, load_rdy=1 throughout.
2. Single play: pattern 8'b0000_1101, len=3, rep=0, one-cycle load_val.
   - f=1,0,1,1 with f_val=1 in cycles 1-4.
   - done=1 only in cycle 4; load_rdy=1 in cycle 4.
   - Cycle 5: f_val=0, f=0.
3. Repeat and stop: pattern 8'b10, len=1, rep=1.
   - f=0,1,0,1,0 in cycles 1-5, with done=0 and load_rdy=0 throughout.
   - stop=1 in cycle 5 -> cycle 6 f_val=0, load_rdy=1.
4. Gapless back-to-back: play 8'b11 (len=1, rep=0) and hold load_val with 8'b00 (len=2).
   - Second load is accepted in cycle 2, the done cycle.
   - f=1,1,0,0,0 with f_val=1 in cycles 1-5, done in cycles 2 and 5, IDLE in cycle 6.
   - Repeat with stop=1 in cycle 2: the load is refused (load_rdy=0) and cycle 3 has f_val=0.
5. Full length and asynchronous reset: pattern 8'hA5, len=7, rep=0 -> f=1,0,1,0,0,1,0,1.
   - Replay it and assert reset=0 mid-cycle 3 -> f_val and f drop to 0 immediately, before the next edge.
   - After release, load_rdy=1 and the next load replays from bit 0.
6. Busy refusal: during a play with len=5, pulse load_val with a different pattern in cycle 2 -> no effect on f; the original 6 bits complete unaltered.

Source files
------------

// File: rtl/seq_waveform_gen_if.sv
// Load handshake and single-bit waveform bus of the serial waveform transmitter.
// The master is the pattern source and waveform sink; the slave is the transmitter.
interface seq_waveform_gen_if #(
  parameter int nbits = 16
);
  localparam int LW = $clog2(nbits);

  logic             load_val;
  logic             load_rdy;
  logic [nbits-1:0] load_pattern;
  logic [LW-1:0]    load_len;
  logic             load_repeat;
  logic             stop;
  logic             f;
  logic             f_val;
  logic             done;

  modport master (
    output load_val, load_pattern, load_len, load_repeat, stop,
    input  load_rdy, f, f_val, done
  );

  modport slave (
    input  load_val, load_pattern, load_len, load_repeat, stop,
    output load_rdy, f, f_val, done
  );
endinterface

// File: rtl/seq_waveform_gen.sv
// Serial waveform transmitter: latches a pattern over a valid/ready load and
// plays it LSB first on f, once or looped, with gapless back-to-back loads.
module seq_waveform_gen #(
  parameter int nbits = 16
) (
  input  logic              clk,
  input  logic              reset,
  seq_waveform_gen_if.slave bus
);
  localparam int LW = $clog2(nbits);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e           fsm_q, fsm_d;
  logic [nbits-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic             rep_q, rep_d;

  logic play;
  logic last;
  logic doneInt;
  logic loadRdy;
  logic accept;

  assign play    = (fsm_q == PLAY);
  assign last    = play && (idx_q == len_q);
  assign doneInt = last && !rep_q;
  assign loadRdy = !play || (doneInt && !bus.stop);
  assign accept  = bus.load_val && loadRdy;

  assign bus.f        = play ? pat_q[idx_q] : 1'b0;
  assign bus.f_val    = play;
  assign bus.done     = doneInt;
  assign bus.load_rdy = loadRdy;

  // stop outranks every advance; a load is only taken in IDLE or on a non-repeat last bit
  always_comb begin
    fsm_d = fsm_q;
    pat_d = pat_q;
    len_d = len_q;
    rep_d = rep_q;
    idx_d = idx_q;
    if (!play) begin
      if (accept) begin
        fsm_d = PLAY;
        pat_d = bus.load_pattern;
        len_d = bus.load_len;
        rep_d = bus.load_repeat;
        idx_d = '0;
      end
    end else if (bus.stop) begin
      fsm_d = IDLE;
    end else if (idx_q < len_q) begin
      idx_d = idx_q + 1'b1;
    end else if (rep_q) begin
      idx_d = '0;
    end else if (accept) begin
      pat_d = bus.load_pattern;
      len_d = bus.load_len;
      rep_d = bus.load_repeat;
      idx_d = '0;
    end else begin
      fsm_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      rep_q <= 1'b0;
      idx_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      pat_q <= pat_d;
      len_q <= len_d;
      rep_q <= rep_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_seq_waveform_gen.sv
// Directed, table-driven bench for seq_waveform_gen with nbits=8; expected
// outputs are packed as {f, f_val, done, load_rdy}.
module tb_seq_waveform_gen;
  localparam int NB = 8;
  localparam int LW = $clog2(NB);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_waveform_gen_if #(.nbits(NB)) bus ();

  seq_waveform_gen #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          lv;
    logic [NB-1:0] pat;
    logic [LW-1:0] len;
    logic          rep;
    logic          stop;
    logic [3:0]    expv;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void addVec(input logic lv, input logic [NB-1:0] pat,
                                 input logic [LW-1:0] len, input logic rep,
                                 input logic stop, input logic [3:0] expv);
    vec_t v;
    v.lv = lv; v.pat = pat; v.len = len; v.rep = rep; v.stop = stop; v.expv = expv;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic lv, input logic [NB-1:0] pat,
                               input logic [LW-1:0] len, input logic rep,
                               input logic stop);
    bus.load_val     = lv;
    bus.load_pattern = pat;
    bus.load_len     = len;
    bus.load_repeat  = rep;
    bus.stop         = stop;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expv);
    logic [3:0] act;
    act = {bus.f, bus.f_val, bus.done, bus.load_rdy};
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: f/f_val/done/load_rdy got %b expected %b", name, act, expv);
    end
  endtask

  // Move to 1ns after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // reset held with stop toggling, then released mid-cycle
    #2 checkOutput("reset_start", 4'b0001);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, (i == 0));
      #1 checkOutput($sformatf("reset_hold%0d", i), 4'b0001);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, (i != 1));
      #1 checkOutput($sformatf("idle_stop%0d", i), 4'b0001);
    end

    // single play of 4'b1101
    addVec(1, 8'h0D, 3, 0, 0, 4'b0001);
    addVec(0, 8'h00, 0, 0, 0, 4'b1100);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1111);
    addVec(0, 8'h00, 0, 0, 0, 4'b0001);
    // repeat 2'b10 then stop in cycle 5
    addVec(1, 8'h02, 1, 1, 0, 4'b0001);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1100);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1100);
    addVec(0, 8'h00, 0, 0, 1, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b0001);
    // gapless back-to-back: 2'b11 then 3'b000 taken in the done cycle
    addVec(1, 8'h03, 1, 0, 0, 4'b0001);
    addVec(1, 8'h00, 2, 0, 0, 4'b1100);
    addVec(1, 8'h00, 2, 0, 0, 4'b1111);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b0111);
    addVec(0, 8'h00, 0, 0, 0, 4'b0001);
    // same, but stop in the done cycle refuses the second load
    addVec(1, 8'h03, 1, 0, 0, 4'b0001);
    addVec(1, 8'h00, 2, 0, 0, 4'b1100);
    addVec(1, 8'h00, 2, 0, 1, 4'b1110);
    addVec(0, 8'h00, 0, 0, 0, 4'b0001);
    // busy refusal during a 6-bit play of 6'b101100
    addVec(1, 8'h2C, 5, 0, 0, 4'b0001);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(1, 8'hFF, 0, 1, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1100);
    addVec(0, 8'h00, 0, 0, 0, 4'b0100);
    addVec(0, 8'h00, 0, 0, 0, 4'b1111);
    addVec(0, 8'h00, 0, 0, 0, 4'b0001);
    // one-bit pattern: upper bits never appear
    addVec(1, 8'hFF, 0, 0, 0, 4'b0001);
    addVec(0, 8'h00, 0, 0, 0, 4'b1111);
    addVec(0, 8'h00, 0, 0, 0, 4'b0001);

    foreach (vecs[i]) begin
      nextCycle();
      applyStimulus(vecs[i].lv, vecs[i].pat, vecs[i].len, vecs[i].rep, vecs[i].stop);
      #1 checkOutput($sformatf("vec%0d", i), vecs[i].expv);
    end

    // full-length play of 8'hA5
    nextCycle();
    applyStimulus(1'b1, 8'hA5, 3'd7, 1'b0, 1'b0);
    #1 checkOutput("full_load", 4'b0001);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] refPat;
      logic       last;
      refPat = 8'hA5;
      last   = (k == 7);
      nextCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      #1 checkOutput($sformatf("full_bit%0d", k), {refPat[k], 1'b1, last, last});
    end

    // replay, then asynchronous reset in the middle of cycle 3
    nextCycle();
    applyStimulus(1'b1, 8'hA5, 3'd7, 1'b0, 1'b0);
    #1 checkOutput("replay_load", 4'b0001);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #1 checkOutput("replay_c1", 4'b1100);
    nextCycle();
    #1 checkOutput("replay_c2", 4'b0100);
    nextCycle();
    #1 checkOutput("replay_c3", 4'b1100);
    #1 reset = 1'b0;
    #1 checkOutput("async_reset", 4'b0001);
    nextCycle();
    checkOutput("reset_held", 4'b0001);
    reset = 1'b1;
    applyStimulus(1'b1, 8'hA5, 3'd7, 1'b0, 1'b0);
    #1 checkOutput("post_reset_rdy", 4'b0001);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #1 checkOutput("post_reset_c1", 4'b1100);
    nextCycle();
    #1 checkOutput("post_reset_c2", 4'b0100);
    nextCycle();
    #1 checkOutput("post_reset_c3", 4'b1100);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    #1 checkOutput("post_reset_stop", 4'b0100);
    nextCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #1 checkOutput("post_reset_idle", 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
